// File: rtl/sram_mem_controller.sv
// MEM-stage data memory sequencer: one 32-bit load/store becomes two 16-bit
// SRAM halfword accesses, stalling the pipeline through ready.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   wr_en, rd_en    store / load request (both high = store)
//   address         CPU byte address (ADDR_OFFSET subtracted internally)
//   write_data      store data
//   read_data       load result (registered; bypassed on buffer hit)
//   ready           access complete or no request; freeze = ~ready
//   sram_addr       halfword address (low half even, high half odd)
//   sram_dq_out     data driven to SRAM during writes
//   sram_dq_in      data returned by SRAM during reads
//   sram_dq_oe      1 = controller drives DQ
//   sram_we_n       active-low write strobe
//
// Optional macro SRAM_CTRL_RDHIT_EN adds a one-entry read buffer that
// answers a repeated load of the same word in zero cycles.
module sram_mem_controller #(
    parameter int unsigned ADDR_OFFSET = 1024,
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int WW = SRAM_ADDR_W - 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            op_wr_q;
    logic [WW-1:0]   word_q;
    logic [15:0]     whi_q;
    logic [15:0]     lo_q;
    logic [31:0]     read_data_q;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic [15:0]     dq_out_q;
    logic            oe_q;
    logic            we_n_q;

    logic [WW-1:0]   word_w;
    logic            last;
    logic            hit;
    logic            start;

    // Word index wraps modulo the SRAM size; addresses below the
    // offset simply alias to the top of the SRAM.
    assign word_w = WW'((address - ADDR_OFFSET) >> 2);
    assign last   = (cnt_q == CW'(WAIT_CYCLES - 1));
    assign start  = (state_q == IDLE) & (rd_en | wr_en) & ~hit;

    assign ready  = ((state_q == IDLE) & ~rd_en & ~wr_en)
                  | (state_q == DONE) | hit;

    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

`ifdef SRAM_CTRL_RDHIT_EN
    logic          buf_v_q;
    logic [WW-1:0] buf_tag_q;
    logic [31:0]   buf_data_q;
    logic [15:0]   wlo_q;

    assign hit = (state_q == IDLE) & rd_en & ~wr_en
               & buf_v_q & (buf_tag_q == word_w);
    assign read_data = hit ? buf_data_q : read_data_q;

    // Filled by completed reads; a completed write to the tagged word
    // keeps the buffered copy coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v_q    <= 1'b0;
            buf_tag_q  <= '0;
            buf_data_q <= '0;
            wlo_q      <= '0;
        end else begin
            if (start) begin
                wlo_q <= write_data[15:0];
            end
            if (state_q == HI && last) begin
                if (!op_wr_q) begin
                    buf_v_q    <= 1'b1;
                    buf_tag_q  <= word_q;
                    buf_data_q <= {sram_dq_in, lo_q};
                end else if (buf_v_q && buf_tag_q == word_q) begin
                    buf_data_q <= {whi_q, wlo_q};
                end
            end
        end
    end
`else
    assign hit       = 1'b0;
    assign read_data = read_data_q;
`endif

    // SRAM pins are registered so address/data/strobe are set on the
    // edge entering a phase and stay stable for all of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            whi_q       <= '0;
            lo_q        <= '0;
            read_data_q <= '0;
            addr_q      <= '0;
            dq_out_q    <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LO;
                        cnt_q   <= '0;
                        op_wr_q <= wr_en;
                        word_q  <= word_w;
                        whi_q   <= write_data[31:16];
                        addr_q  <= {word_w, 1'b0};
                        if (wr_en) begin
                            dq_out_q <= write_data[15:0];
                            oe_q     <= 1'b1;
                            we_n_q   <= 1'b0;
                        end
                    end
                end
                LO: begin
                    if (last) begin
                        state_q <= HI;
                        cnt_q   <= '0;
                        lo_q    <= sram_dq_in;
                        addr_q  <= {word_q, 1'b1};
                        if (op_wr_q) begin
                            dq_out_q <= whi_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HI: begin
                    if (last) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        oe_q    <= 1'b0;
                        we_n_q  <= 1'b1;
                        if (!op_wr_q) begin
                            read_data_q <= {sram_dq_in, lo_q};
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: SRAM model, table vectors,
// hand-written corner sequences and random traffic against a word model.
module tb_sram_mem_controller;

    localparam int W    = 2;
    localparam int MISS = 2 * W + 1;
`ifdef SRAM_CTRL_RDHIT_EN
    localparam bit RDHIT = 1'b1;
`else
    localparam bit RDHIT = 1'b0;
`endif
    localparam int HL = RDHIT ? 0 : MISS;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    sram_mem_controller #(
        .ADDR_OFFSET(1024),
        .SRAM_ADDR_W(18),
        .WAIT_CYCLES(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External SRAM model plus activity counters (never reset; deltas used)
    logic [15:0] sram [0:262143];
    int          we_cyc   = 0;
    int          addr_chg = 0;
    logic [17:0] prev_addr = '0;

    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram[sram_addr] <= sram_dq_out;
            we_cyc <= we_cyc + 1;
        end
        if (sram_addr != prev_addr) addr_chg <= addr_chg + 1;
        prev_addr <= sram_addr;
    end

    always @(negedge clk) sram_dq_in <= sram[sram_addr];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Word-level reference: 32-bit words, one-entry buffer semantics
    logic [31:0] mdl [int];
    bit          bv;
    int          btag;
    logic [31:0] bdata;
    logic [31:0] last_rd;

    task automatic model_reset();
        bv      = 1'b0;
        last_rd = '0;
    endtask

    task automatic model_step(input bit r, input bit w,
                              input logic [31:0] a, input logic [31:0] d,
                              output int lat, output logic [31:0] rdv);
        logic [31:0] off;
        int          wi;
        off = a - 32'd1024;
        wi  = int'(off >> 2) & 32'h1FFFF;
        lat = MISS;
        rdv = last_rd;
        if (w) begin
            mdl[wi] = d;
            if (RDHIT && bv && btag == wi) bdata = d;
        end else if (r) begin
            if (RDHIT && bv && btag == wi) begin
                lat = 0;
                rdv = bdata;
            end else begin
                rdv     = mdl.exists(wi) ? mdl[wi] : 32'h0;
                last_rd = rdv;
                if (RDHIT) begin
                    bv    = 1'b1;
                    btag  = wi;
                    bdata = rdv;
                end
            end
        end
    endtask

    task automatic run_txn(input bit r, input bit w,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rdv,
                           output int wes, output int chg);
        int we0;
        int ch0;
        bit done;
        @(posedge clk);
        #1;
        rd_en = r;
        wr_en = w;
        address = a;
        write_data = d;
        we0  = we_cyc;
        ch0  = addr_chg;
        lat  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
            end else begin
                lat++;
                if (lat > 40) done = 1'b1;
            end
        end
        rdv = read_data;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        wes = we_cyc - we0;
        chg = addr_chg - ch0;
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic [31:0] rd;
        int          sa;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          elat;
        int          wes;
        int          chg;
        int          w0;
        logic [31:0] rdv;
        logic [31:0] erd;

        tbl.push_back('{1, 0, 32'd0, 32'd0, 0, 32'd0, -1});
        tbl.delete();
        tbl.push_back('{0, 1, 32'd1024,   32'hDEADBEEF, MISS, 32'h0,        0});
        tbl.push_back('{1, 0, 32'd1024,   32'h0,        MISS, 32'hDEADBEEF, -1});
        tbl.push_back('{1, 0, 32'd1024,   32'h0,        HL,   32'hDEADBEEF, -1});
        tbl.push_back('{1, 1, 32'd1032,   32'h12345678, MISS, 32'h0,        4});
        tbl.push_back('{1, 0, 32'd1032,   32'h0,        MISS, 32'h12345678, -1});
        tbl.push_back('{0, 1, 32'd1020,   32'hA5A55A5A, MISS, 32'h0,   262142});
        tbl.push_back('{1, 0, 32'd525308, 32'h0,        MISS, 32'hA5A55A5A, -1});
        tbl.push_back('{1, 0, 32'd1033,   32'h0,        MISS, 32'h12345678, -1});
        tbl.push_back('{0, 1, 32'd1032,   32'h0BADC0DE, MISS, 32'h0,        4});
        tbl.push_back('{1, 0, 32'd1032,   32'h0,        HL,   32'h0BADC0DE, -1});
        tbl.push_back('{0, 1, 32'd1040,   32'h11112222, MISS, 32'h0,        8});
        tbl.push_back('{1, 0, 32'd1035,   32'h0,        HL,   32'h0BADC0DE, -1});

        rst = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        address = '0;
        write_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
        chk("idle_oe", 32'(sram_dq_oe), 32'd0);
        chk("idle_rdata", read_data, 32'h0);

        // Reset pulsed in cycle 2 of a read aborts it
        @(posedge clk);
        #1;
        rd_en = 1'b1;
        address = 32'd1028;
        w0 = we_cyc;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_rdata", read_data, 32'h0);
        repeat (MISS + 2) @(negedge clk);
        chk("abort_stays_idle", 32'(ready), 32'd1);
        chk("abort_no_write", 32'(we_cyc - w0), 32'd0);
        chk("abort_rdata_hold", read_data, 32'h0);

        foreach (tbl[i]) begin
            model_step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, elat, erd);
            run_txn(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, lat, rdv, wes, chg);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d_we_cycles", i), 32'(wes),
                tbl[i].w ? 32'd4 : 32'd0);
            if (!tbl[i].w)
                chk($sformatf("tbl%0d_rdata", i), rdv, tbl[i].rd);
            if (tbl[i].lat == 0)
                chk($sformatf("tbl%0d_no_sram_activity", i), 32'(chg), 32'd0);
            if (tbl[i].sa >= 0) begin
                chk($sformatf("tbl%0d_sram_lo", i),
                    32'(sram[tbl[i].sa]), 32'(tbl[i].d[15:0]));
                chk($sformatf("tbl%0d_sram_hi", i),
                    32'(sram[tbl[i].sa + 1]), 32'(tbl[i].d[31:16]));
            end
        end

        // Store request dropped after cycle 0 still completes from the latch
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        address = 32'd1048;
        write_data = 32'h55AA33CC;
        @(negedge clk);
        chk("drop_c0_ready", 32'(ready), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                wr_en = 1'b0;
                address = 32'd2000;
                write_data = 32'h0;
            end
            @(negedge clk);
            chk($sformatf("drop_c%0d_we_n", c), 32'(sram_we_n), 32'd0);
            chk($sformatf("drop_c%0d_oe", c), 32'(sram_dq_oe), 32'd1);
            chk($sformatf("drop_c%0d_addr", c), 32'(sram_addr),
                (c <= 2) ? 32'd12 : 32'd13);
            chk($sformatf("drop_c%0d_dq", c), 32'(sram_dq_out),
                (c <= 2) ? 32'h33CC : 32'h55AA);
            chk($sformatf("drop_c%0d_ready", c), 32'(ready), 32'd0);
        end
        @(negedge clk);
        chk("drop_c5_ready", 32'(ready), 32'd1);
        chk("drop_c5_we_n", 32'(sram_we_n), 32'd1);
        chk("drop_c5_oe", 32'(sram_dq_oe), 32'd0);
        chk("drop_sram_lo", 32'(sram[12]), 32'h33CC);
        chk("drop_sram_hi", 32'(sram[13]), 32'h55AA);
        model_step(1'b0, 1'b1, 32'd1048, 32'h55AA33CC, elat, erd);

        // Random traffic over a small word window so buffer hits occur
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'd1024 + 32'(4 * k);
            d = $urandom;
            model_step(1'b0, 1'b1, a, d, elat, erd);
            run_txn(1'b0, 1'b1, a, d, lat, rdv, wes, chg);
            chk("init_lat", 32'(lat), 32'(elat));
        end
        for (int n = 0; n < 80; n++) begin
            int          op;
            bit          r;
            bit          w;
            logic [31:0] a;
            logic [31:0] d;
            op = $urandom_range(0, 2);
            r  = (op != 1);
            w  = (op != 0);
            a  = 32'd1024 + 32'(4 * $urandom_range(0, 7))
               + 32'($urandom_range(0, 3));
            d  = $urandom;
            model_step(r, w, a, d, elat, erd);
            run_txn(r, w, a, d, lat, rdv, wes, chg);
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(elat));
            if (!w) chk($sformatf("rnd%0d_rdata", n), rdv, erd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
